// File: rtl/serial_wide_adder_pkg.sv
// Shared types for the slice-serial wide adder.
package serial_wide_adder_pkg;

  // Control states of the serial adder.
  //   IDLE - waiting for a request (in_ready high)
  //   RUN  - one slice of the operands is added per clock
  //   DONE - result presented until the consumer takes it
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of a counter that indexes n items. The result is never less than 1
  // bit, so a single-slice configuration still gets a legal index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_in_chain.sv
// One link of a ripple chain: width-bit add with carry in and carry out.
module adder_in_chain #(
  parameter int width = 16
) (
  input  logic [width-1:0] lhs_i,
  input  logic [width-1:0] rhs_i,
  input  logic             icarry,
  output logic [width-1:0] sum_o,
  output logic             ocarry
);

  // Add with one extra bit of headroom; the top bit is the carry out.
  always_comb begin
    {ocarry, sum_o} = {1'b0, lhs_i} + {1'b0, rhs_i} + {{width{1'b0}}, icarry};
  end

endmodule

// File: rtl/serial_wide_adder.sv
// Wide adder that processes one slice_width-bit slice per clock, least
// significant slice first, carrying between slices through a register.
// A request is accepted in IDLE, takes N = width/slice_width clocks in RUN,
// and the result is held in DONE until out_ready.
module serial_wide_adder
  import serial_wide_adder_pkg::*;
#(
  parameter int width       = 64,
  parameter int slice_width = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_lhs,
  input  logic [width-1:0] in_rhs,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_sum,
  output logic             out_carry,
  output logic             busy
);

  localparam int N     = width / slice_width;
  localparam int IDX_W = idx_width(N);

  // Refuse to elaborate a configuration that does not split into whole slices.
  generate
    if (slice_width < 1 || width < slice_width || (width % slice_width) != 0) begin : g_bad_params
      $error("serial_wide_adder: width (%0d) must be a positive multiple of slice_width (%0d)",
             width, slice_width);
    end
  endgenerate

  // Operands and result viewed as arrays of slices, indexed by the slice counter.
  typedef logic [N-1:0][slice_width-1:0] slices_t;
  typedef logic [IDX_W-1:0]              idx_t;

  state_e  state_q, state_d;
  slices_t lhs_q, lhs_d;
  slices_t rhs_q, rhs_d;
  slices_t sum_q, sum_d;
  idx_t    idx_q, idx_d;
  logic    carry_q, carry_d;
  logic    out_carry_q, out_carry_d;

  logic [slice_width-1:0] slice_sum;
  logic                   slice_carry;
  logic                   last_slice;

  // The only arithmetic on operand data: the current slice plus the carry
  // left over from the previous slice.
  adder_in_chain #(
    .width (slice_width)
  ) u_slice_add (
    .lhs_i  (lhs_q[idx_q]),
    .rhs_i  (rhs_q[idx_q]),
    .icarry (carry_q),
    .sum_o  (slice_sum),
    .ocarry (slice_carry)
  );

  assign last_slice = (idx_q == idx_t'(N - 1));

  // Next-state and datapath steering for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    // NOTE: every _d signal is given its hold value first; any path through the
    // case that does not override it keeps the register, so no latch is inferred.
    state_d     = state_q;
    lhs_d       = lhs_q;
    rhs_d       = rhs_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    out_carry_d = out_carry_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          lhs_d       = in_lhs;
          rhs_d       = in_rhs;
          carry_d     = in_carry;
          sum_d       = '0;
          out_carry_d = 1'b0;
          idx_d       = '0;
          state_d     = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q] = slice_sum;
        carry_d      = slice_carry;
        if (last_slice) begin
          // Index stays at N-1 so it can never wrap into a second pass.
          out_carry_d = slice_carry;
          state_d     = DONE;
        end else begin
          idx_d = idx_q + idx_t'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state and result registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register here samples the values
    // from before the edge, independent of statement order.
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      out_carry_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      sum_q       <= sum_d;
      out_carry_q <= out_carry_d;
    end
  end

  // Operand holding registers.
  always_ff @(posedge clk) begin
    // NOTE: no reset on the operand registers; they are always loaded on the
    // accepting edge before being read, so clearing them buys nothing.
    lhs_q <= lhs_d;
    rhs_q <= rhs_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_sum   = sum_q;
  assign out_carry = out_carry_q;

endmodule
